// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter.
// Loads a parallel pattern, its length and a repeat count, then shifts the
// pattern out MSB-first, one bit per clock. Repetitions follow with no gap.
// All outputs are registered. The FSM is Moore-style with the states IDLE,
// SHIFT and DONE.
module seq_pattern_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned CNT_W      = 4,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

    state_t             state, state_n;
    logic [WIDTH-1:0]   pat, pat_n, pat_sh;
    logic [LEN_W-1:0]   plen, plen_n;
    logic [LEN_W-1:0]   idx, idx_n;
    logic [CNT_W-1:0]   reps, reps_n;
    logic               fin, fin_n;
    logic               x_n, x_valid_n, busy_n, done_n;
    logic [LEN_W-1:0]   len_clamped;

    // Clamp the requested length: 0 or anything beyond WIDTH means a full-width pattern
    always_comb begin
        len_clamped = len;
        if (len == '0 || len > WIDTH_L) begin
            len_clamped = WIDTH_L;
        end
    end

    // Next-state and next-output logic. The SHIFT cycle that follows the
    // acceptance of start only loads the pattern, and fin marks that bit 0 of
    // the last repetition has just been put on x
    always_comb begin
        state_n   = state;
        pat_n     = pat;
        plen_n    = plen;
        idx_n     = idx;
        reps_n    = reps;
        fin_n     = fin;
        x_n       = IDLE_LEVEL;
        x_valid_n = 1'b0;
        busy_n    = busy;
        done_n    = 1'b0;
        pat_sh    = pat >> idx;

        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (start) begin
                    state_n = SHIFT;
                    pat_n   = pattern;
                    plen_n  = len_clamped;
                    idx_n   = len_clamped - LEN_W'(1);
                    reps_n  = repeat_n;
                    fin_n   = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            SHIFT: begin
                busy_n = 1'b1;
                if (fin) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    fin_n   = 1'b0;
                end else begin
                    x_n       = pat_sh[0];
                    x_valid_n = 1'b1;
                    if (idx == '0) begin
                        if (reps == '0) begin
                            fin_n = 1'b1;
                        end else begin
                            reps_n = reps - CNT_W'(1);
                            idx_n  = plen - LEN_W'(1);
                        end
                    end else begin
                        idx_n = idx - LEN_W'(1);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State, latched-copy and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pat     <= '0;
            plen    <= '0;
            idx     <= '0;
            reps    <= '0;
            fin     <= 1'b0;
            x       <= IDLE_LEVEL;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            pat     <= pat_n;
            plen    <= plen_n;
            idx     <= idx_n;
            reps    <= reps_n;
            fin     <= fin_n;
            x       <= x_n;
            x_valid <= x_valid_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx with WIDTH=8.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] repeat_n;
    logic       x, x_valid, busy, done;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    seq_pattern_tx #(
        .WIDTH(8),
        .LEN_W(4),
        .CNT_W(4),
        .IDLE_LEVEL(1'b0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .pattern(pattern),
        .len(len),
        .repeat_n(repeat_n),
        .x(x),
        .x_valid(x_valid),
        .busy(busy),
        .done(done)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int idx, input logic ex, input logic ev,
                           input logic eb, input logic ed);
        chk({tag, "_x"}, idx, x, ex);
        chk({tag, "_valid"}, idx, x_valid, ev);
        chk({tag, "_busy"}, idx, busy, eb);
        chk({tag, "_done"}, idx, done, ed);
    endtask

    // One transmission from IDLE. bits holds the hand-computed stream, first bit
    // at position n-1. disturb pulses start and new inputs mid-stream.
    // start_in_done raises start in the DONE cycle and checks it is ignored there
    // but accepted in the following IDLE cycle (a 2-bit 2'b11 transfer).
    task automatic send(input string tag, input logic [7:0] p, input logic [3:0] l,
                        input logic [3:0] r, input logic [15:0] bits, input int n,
                        input bit disturb, input bit start_in_done);
        pattern  = p;
        len      = l;
        repeat_n = r;
        start    = 1'b1;
        tick();
        chk_out({tag, "_load"}, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (disturb && i == 1) begin
                start    = 1'b1;
                pattern  = 8'hFF;
                len      = 4'd2;
                repeat_n = 4'd5;
            end
            if (disturb && i == 2) start = 1'b0;
            tick();
            chk_out({tag, "_bit"}, i, bits[n-1-i], 1'b1, 1'b1, 1'b0);
        end
        tick();
        chk_out({tag, "_done"}, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        if (start_in_done) begin
            start    = 1'b1;
            pattern  = 8'h03;
            len      = 4'd2;
            repeat_n = 4'd0;
            tick();
            chk_out({tag, "_dstart_ign"}, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            chk_out({tag, "_dstart_acc"}, 0, 1'b0, 1'b0, 1'b1, 1'b0);
            start = 1'b0;
            tick();
            chk_out({tag, "_dstart_bit"}, 0, 1'b1, 1'b1, 1'b1, 1'b0);
            tick();
            chk_out({tag, "_dstart_bit"}, 1, 1'b1, 1'b1, 1'b1, 1'b0);
            tick();
            chk_out({tag, "_dstart_done"}, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        tick();
        chk_out({tag, "_idle"}, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        pattern  = '0;
        len      = '0;
        repeat_n = '0;
        tick();
        tick();
        chk_out("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk_out("post_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Basic: low 4 bits of 0000_0110 -> 0,1,1,0
        send("basic", 8'b0000_0110, 4'd4, 4'd0, 16'b0110, 4, 1'b0, 1'b0);
        // Three contiguous repetitions of 0110
        send("repeat", 8'b0000_0110, 4'd4, 4'd2, 16'b0110_0110_0110, 12, 1'b0, 1'b0);
        // Length clamps: 0 and 12 both mean 8 bits of A5
        send("clamp0", 8'hA5, 4'd0, 4'd0, 16'b1010_0101, 8, 1'b0, 1'b0);
        send("clamp12", 8'hA5, 4'd12, 4'd0, 16'b1010_0101, 8, 1'b0, 1'b0);
        // Mid-stream start/pattern changes leave the stream 1,1,0,0,1 unchanged
        send("ignore", 8'b0001_1001, 4'd5, 4'd0, 16'b11001, 5, 1'b1, 1'b0);
        // Single-bit pattern repeated four times
        send("min", 8'h01, 4'd1, 4'd3, 16'b1111, 4, 1'b0, 1'b0);
        // Start during DONE is ignored, then accepted one cycle later
        send("dstart", 8'b0000_0101, 4'd3, 4'd0, 16'b101, 3, 1'b0, 1'b1);

        // Reset abort while bit 2 of 1011 is on x
        pattern  = 8'b0000_1011;
        len      = 4'd4;
        repeat_n = 4'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_out("abort_bit", 0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("abort_bit", 1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("abort_bit", 2, 1'b1, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        chk_out("abort_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("abort_quiet", i, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        // Fresh start after the abort
        send("after_abort", 8'b1100_0000, 4'd8, 4'd0, 16'b1100_0000, 8, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
